// File: rtl/hack_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hack_pkg
// Purpose  : Shared definitions for the Hack CPU control core. Holds the
//            state encoding, the instruction field positions, the ALU
//            control bit order and the default reset PC.
// Revision : 1.0 - initial release
// ============================================================================
package hack_pkg;

  // Control FSM states. ST_HALT is only entered when HACK_CPU_HALT_EN is defined.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEM_RD = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM_WR = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // Instruction field positions
  localparam int INSN_CBIT = 15;  // 0 = A-instruction, 1 = C-instruction
  localparam int INSN_ABIT = 12;  // ALU y operand: 1 = M, 0 = A
  localparam int COMP_MSB  = 11;
  localparam int COMP_LSB  = 6;
  localparam int DEST_A    = 5;
  localparam int DEST_D    = 4;
  localparam int DEST_M    = 3;
  localparam int JUMP_MSB  = 2;
  localparam int JUMP_LSB  = 0;

  // ALU control bit order within alu_ctl
  localparam int ALU_ZX = 5;
  localparam int ALU_NX = 4;
  localparam int ALU_ZY = 3;
  localparam int ALU_NY = 2;
  localparam int ALU_F  = 1;
  localparam int ALU_NO = 0;

  localparam logic [14:0] DEFAULT_RESET_PC = 15'd0;

endpackage
`default_nettype wire

// File: rtl/hack_cpu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : hack_cpu_ctrl_if
// Purpose  : Instruction and data memory handshake bundle. The CPU is the
//            master; the memory system is the slave.
// Revision : 1.0 - initial release
// ============================================================================
interface hack_cpu_ctrl_if;
  logic        imem_req;
  logic [14:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_valid;
  logic        dmem_rd;
  logic        dmem_wr;
  logic [14:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_rd, dmem_wr, dmem_addr, dmem_wdata,
    input  imem_data, imem_valid, dmem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_rd, dmem_wr, dmem_addr, dmem_wdata,
    output imem_data, imem_valid, dmem_rdata, dmem_ack
  );
endinterface
`default_nettype wire

// File: rtl/hack_alu.sv
`default_nettype none
// ============================================================================
// Module   : hack_alu
// Purpose  : Standard combinational Hack ALU (zx,nx,zy,ny,f,no) with zr/ng.
// Revision : 1.0 - initial release
// ============================================================================
module hack_alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [5:0]  ctl,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);
  logic [15:0] x_z, x_n, y_z, y_n, f_out;

  assign x_z   = ctl[5] ? 16'h0000 : x;
  assign x_n   = ctl[4] ? ~x_z : x_z;
  assign y_z   = ctl[3] ? 16'h0000 : y;
  assign y_n   = ctl[2] ? ~y_z : y_z;
  assign f_out = ctl[1] ? (x_n + y_n) : (x_n & y_n);
  assign out   = ctl[0] ? ~f_out : f_out;
  assign zr    = (out == 16'h0000);
  assign ng    = out[15];
endmodule
`default_nettype wire

// File: rtl/hack_jump_cond.sv
`default_nettype none
// ============================================================================
// Module   : hack_jump_cond
// Purpose  : Jump decision from the {lt,eq,gt} jump bits and ALU flags.
// Revision : 1.0 - initial release
// ============================================================================
module hack_jump_cond (
  input  logic [2:0] jump,
  input  logic       zr,
  input  logic       ng,
  output logic       taken
);
  assign taken = (jump[2] & ng) | (jump[1] & zr) | (jump[0] & ~ng & ~zr);
endmodule
`default_nettype wire

// File: rtl/hack_cpu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hack_cpu_ctrl
// Purpose  : Multi-cycle Hack CPU control core. Fetches and decodes Hack
//            instructions, owns A/D/PC, drives the ALU and talks to both
//            memories through wait-state tolerant req/valid handshakes.
//            Optional feature macro: HACK_CPU_HALT_EN (jump-to-self halts).
// Revision : 1.0 - initial release
// ============================================================================
module hack_cpu_ctrl
  import hack_pkg::*;
#(
  parameter logic [14:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                  clk,
  input  logic                  reset,
  hack_cpu_ctrl_if.master       bus,
  output logic [5:0]            alu_ctl,
  output logic [14:0]           pc,
  output logic                  retire,
  output logic                  halted
);

  state_t      state, next_state;
  logic [15:0] ir, a_reg, d_reg, mr, res;
  logic [14:0] pc_reg, commit_pc;
  logic        zr_q, ng_q;
  logic        is_c, commit, taken;
  logic        imem_req_c, dmem_rd_c, dmem_wr_c;
  logic [5:0]  comp;
  logic [15:0] alu_y, alu_out, cur_res;
  logic        alu_zr, alu_ng, cur_zr, cur_ng;
  logic        unused_ir_bits;

  assign is_c           = ir[INSN_CBIT];
  assign comp           = ir[COMP_MSB:COMP_LSB];
  assign unused_ir_bits = &{1'b0, ir[14:13]};

  // x is always D; y selects the fetched M operand or A
  assign alu_y = ir[INSN_ABIT] ? mr : a_reg;

  hack_alu u_alu (
    .x   (d_reg),
    .y   (alu_y),
    .ctl (comp),
    .out (alu_out),
    .zr  (alu_zr),
    .ng  (alu_ng)
  );

  // EXEC commits straight from the ALU; MEM_WR commits from the latched copy
  assign cur_res = (state == ST_EXEC) ? alu_out : res;
  assign cur_zr  = (state == ST_EXEC) ? alu_zr  : zr_q;
  assign cur_ng  = (state == ST_EXEC) ? alu_ng  : ng_q;

  hack_jump_cond u_jump (
    .jump  (ir[JUMP_MSB:JUMP_LSB]),
    .zr    (cur_zr),
    .ng    (cur_ng),
    .taken (taken)
  );

  // Jump target is the pre-instruction A; A-instructions never jump
  assign commit_pc = (is_c && taken) ? a_reg[14:0] : pc_reg + 15'd1;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_FETCH;
    else       state <= next_state;
  end

  // Next-state, request and commit decode
  always_comb begin
    next_state = state;
    commit     = 1'b0;
    imem_req_c = 1'b0;
    dmem_rd_c  = 1'b0;
    dmem_wr_c  = 1'b0;
    case (state)
      ST_FETCH: begin
        imem_req_c = 1'b1;
        if (bus.imem_valid) next_state = ST_DECODE;
      end
      ST_DECODE: begin
        if (!is_c) begin
          commit     = 1'b1;
          next_state = ST_FETCH;
        end else if (ir[INSN_ABIT]) begin
          next_state = ST_MEM_RD;
        end else begin
          next_state = ST_EXEC;
        end
      end
      ST_MEM_RD: begin
        dmem_rd_c = 1'b1;
        if (bus.dmem_ack) next_state = ST_EXEC;
      end
      ST_EXEC: begin
        if (ir[DEST_M]) begin
          next_state = ST_MEM_WR;
        end else begin
          commit     = 1'b1;
          next_state = ST_FETCH;
        end
      end
      ST_MEM_WR: begin
        dmem_wr_c = 1'b1;
        if (bus.dmem_ack) begin
          commit     = 1'b1;
          next_state = ST_FETCH;
        end
      end
      ST_HALT: begin
        next_state = ST_HALT;
      end
      default: next_state = ST_FETCH;
    endcase
`ifdef HACK_CPU_HALT_EN
    // An unconditional jump to its own address can never make progress
    if (commit && is_c && (ir[JUMP_MSB:JUMP_LSB] == 3'b111) && (a_reg[14:0] == pc_reg))
      next_state = ST_HALT;
`endif
  end

  // Datapath registers; A, D and PC only change together on the commit edge
  always_ff @(posedge clk) begin
    if (reset) begin
      ir     <= 16'h0000;
      a_reg  <= 16'h0000;
      d_reg  <= 16'h0000;
      mr     <= 16'h0000;
      res    <= 16'h0000;
      zr_q   <= 1'b0;
      ng_q   <= 1'b0;
      pc_reg <= RESET_PC;
    end else begin
      if (state == ST_FETCH && bus.imem_valid) ir <= bus.imem_data;
      if (state == ST_MEM_RD && bus.dmem_ack)  mr <= bus.dmem_rdata;
      if (state == ST_EXEC) begin
        res  <= alu_out;
        zr_q <= alu_zr;
        ng_q <= alu_ng;
      end
      if (commit) begin
        pc_reg <= commit_pc;
        if (!is_c) begin
          a_reg <= {1'b0, ir[14:0]};
        end else begin
          if (ir[DEST_A]) a_reg <= cur_res;
          if (ir[DEST_D]) d_reg <= cur_res;
        end
      end
    end
  end

  assign bus.imem_req   = imem_req_c & ~reset;
  assign bus.imem_addr  = pc_reg;
  assign bus.dmem_rd    = dmem_rd_c & ~reset;
  assign bus.dmem_wr    = dmem_wr_c & ~reset;
  assign bus.dmem_addr  = a_reg[14:0];
  assign bus.dmem_wdata = res;

  assign pc      = pc_reg;
  assign retire  = commit & ~reset;
  assign alu_ctl = (is_c && state != ST_FETCH && state != ST_HALT) ? comp : 6'b000000;

`ifdef HACK_CPU_HALT_EN
  assign halted = (state == ST_HALT) & ~reset;
`else
  assign halted = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hack_cpu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hack_cpu_ctrl
// Purpose  : Directed self-checking bench for hack_cpu_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hack_cpu_ctrl;
  import hack_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  alu_ctl;
  logic [14:0] pc;
  logic        retire, halted;

  hack_cpu_ctrl_if bus ();

  hack_cpu_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .alu_ctl (alu_ctl),
    .pc      (pc),
    .retire  (retire),
    .halted  (halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observations from the last executed instruction
  int          n_cyc, wr_cyc;
  logic        rd_seen, wr_seen, wr_unstable;
  logic [14:0] rd_addr, wr_addr;
  logic [15:0] wr_data;
  logic [5:0]  ctl_seen;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.imem_valid = 1'b0;
    bus.dmem_ack   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs one instruction to retirement; called just after a negedge in FETCH.
  task automatic exec_instr(input logic [15:0] instr, input int wdelay, input logic [15:0] rdata);
    int   wcnt;
    logic done;
    wcnt = 0; done = 1'b0;
    n_cyc = 0; wr_cyc = 0; rd_seen = 0; wr_seen = 0; wr_unstable = 0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; ctl_seen = '0;
    while (!done && n_cyc < 40) begin
      #1;
      n_cyc++;
      bus.imem_valid = 1'b0;
      bus.dmem_ack   = 1'b0;
      if (bus.imem_req) begin
        bus.imem_data  = instr;
        bus.imem_valid = 1'b1;
      end
      if (bus.dmem_rd) begin
        rd_seen         = 1'b1;
        rd_addr         = bus.dmem_addr;
        bus.dmem_rdata  = rdata;
        bus.dmem_ack    = 1'b1;
      end
      if (bus.dmem_wr) begin
        if (wr_seen && (wr_addr != bus.dmem_addr || wr_data != bus.dmem_wdata)) wr_unstable = 1'b1;
        wr_seen = 1'b1;
        wr_addr = bus.dmem_addr;
        wr_data = bus.dmem_wdata;
        wr_cyc++;
        if (wcnt == wdelay) bus.dmem_ack = 1'b1;
        else wcnt++;
      end
      #1;
      if (retire) begin
        done     = 1'b1;
        ctl_seen = alu_ctl;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) n_cyc = -1;
    @(posedge clk);
    #1;
    bus.imem_valid = 1'b0;
    bus.dmem_ack   = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.imem_valid = 1'b0; bus.dmem_ack = 1'b0;
    bus.imem_data = '0; bus.dmem_rdata = '0;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if ({bus.imem_req, bus.dmem_rd, bus.dmem_wr, retire, halted} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs: got %b expected 00000",
                         {bus.imem_req, bus.dmem_rd, bus.dmem_wr, retire, halted});
    end
    checks++;
    if (pc !== 15'd0) begin errors++; $display("FAIL reset_pc: got %h expected 0000", pc); end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 15'd0) begin
      errors++; $display("FAIL reset_fetch: req %b addr %h expected req 1 addr 0000", bus.imem_req, bus.imem_addr);
    end
    checks++;
    if (dut.a_reg !== 16'd0 || dut.d_reg !== 16'd0) begin
      errors++; $display("FAIL reset_ad: A %h D %h expected 0000 0000", dut.a_reg, dut.d_reg);
    end
  endtask

  task automatic test_a_instr();
    exec_instr(16'h0005, 0, 16'h0);
    checks++;
    if (n_cyc !== 2) begin errors++; $display("FAIL a_instr_cycles: got %0d expected 2", n_cyc); end
    checks++;
    if (dut.a_reg !== 16'h0005 || pc !== 15'd1) begin
      errors++; $display("FAIL a_instr_commit: A %h pc %h expected A 0005 pc 0001", dut.a_reg, pc);
    end
    checks++;
    if (ctl_seen !== 6'b000000) begin errors++; $display("FAIL a_instr_aluctl: got %b expected 000000", ctl_seen); end
  endtask

  task automatic test_c_dmove();
    do_reset();
    exec_instr(16'h0007, 0, 16'h0);
    exec_instr(16'hEC10, 0, 16'h0);
    checks++;
    if (ctl_seen !== 6'b110000) begin errors++; $display("FAIL dmove_aluctl: got %b expected 110000", ctl_seen); end
    checks++;
    if (dut.d_reg !== 16'd7 || pc !== 15'd2) begin
      errors++; $display("FAIL dmove_commit: D %h pc %h expected D 0007 pc 0002", dut.d_reg, pc);
    end
    checks++;
    if (rd_seen !== 1'b0 || wr_seen !== 1'b0 || n_cyc !== 3) begin
      errors++; $display("FAIL dmove_nomem: rd %b wr %b cycles %0d expected 0 0 3", rd_seen, wr_seen, n_cyc);
    end
  endtask

  task automatic test_mem_write();
    exec_instr(16'h0064, 0, 16'h0);
    exec_instr(16'hE7C8, 3, 16'h0);
    checks++;
    if (wr_seen !== 1'b1 || wr_addr !== 15'd100 || wr_data !== 16'd8) begin
      errors++; $display("FAIL mwr_data: seen %b addr %h data %h expected 1 0064 0008", wr_seen, wr_addr, wr_data);
    end
    checks++;
    if (wr_unstable !== 1'b0 || wr_cyc !== 4) begin
      errors++; $display("FAIL mwr_hold: unstable %b wr_cycles %0d expected 0 4", wr_unstable, wr_cyc);
    end
    checks++;
    if (n_cyc !== 7 || pc !== 15'd4) begin
      errors++; $display("FAIL mwr_retire: cycles %0d pc %h expected 7 0004", n_cyc, pc);
    end
  endtask

  task automatic test_mem_rmw();
    exec_instr(16'h0014, 0, 16'h0);
    exec_instr(16'hFCA8, 0, 16'h0000);
    checks++;
    if (rd_seen !== 1'b1 || rd_addr !== 15'd20) begin
      errors++; $display("FAIL rmw_read: seen %b addr %h expected 1 0014", rd_seen, rd_addr);
    end
    checks++;
    if (wr_addr !== 15'd20 || wr_data !== 16'hFFFF) begin
      errors++; $display("FAIL rmw_write: addr %h data %h expected 0014 ffff", wr_addr, wr_data);
    end
    checks++;
    if (dut.a_reg !== 16'hFFFF || pc !== 15'd6 || n_cyc !== 5) begin
      errors++; $display("FAIL rmw_commit: A %h pc %h cycles %0d expected ffff 0006 5", dut.a_reg, pc, n_cyc);
    end
  endtask

  task automatic test_jump();
    exec_instr(16'hEA90, 0, 16'h0);  // D=0
    exec_instr(16'h0028, 0, 16'h0);
    exec_instr(16'hE302, 0, 16'h0);  // D;JEQ
    checks++;
    if (pc !== 15'd40) begin errors++; $display("FAIL jeq_taken: pc %h expected 0028", pc); end
    exec_instr(16'hEFD0, 0, 16'h0);  // D=1
    exec_instr(16'h0028, 0, 16'h0);
    exec_instr(16'hE302, 0, 16'h0);
    checks++;
    if (pc !== 15'd43) begin errors++; $display("FAIL jeq_not_taken: pc %h expected 002b", pc); end
    do_reset();
    exec_instr(16'h7FFF, 0, 16'h0);
    exec_instr(16'hEA87, 0, 16'h0);  // 0;JMP
    checks++;
    if (pc !== 15'h7FFF) begin errors++; $display("FAIL jmp_far: pc %h expected 7fff", pc); end
    exec_instr(16'h0001, 0, 16'h0);
    checks++;
    if (pc !== 15'd0 || dut.a_reg !== 16'd1) begin
      errors++; $display("FAIL pc_wrap: pc %h A %h expected 0000 0001", pc, dut.a_reg);
    end
  endtask

  task automatic test_halt();
    int reqs;
    do_reset();
    exec_instr(16'h0000, 0, 16'h0);
    exec_instr(16'h0002, 0, 16'h0);
    exec_instr(16'hEA87, 0, 16'h0);  // jump to self at pc 2
    reqs = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.imem_req) reqs++;
      @(negedge clk);
    end
    checks++;
    if (pc !== 15'd2) begin errors++; $display("FAIL self_jump_pc: pc %h expected 0002", pc); end
`ifdef HACK_CPU_HALT_EN
    checks++;
    if (halted !== 1'b1 || reqs !== 0) begin
      errors++; $display("FAIL halt: halted %b fetch_reqs %0d expected 1 0", halted, reqs);
    end
`else
    checks++;
    if (halted !== 1'b0 || reqs === 0) begin
      errors++; $display("FAIL no_halt: halted %b fetch_reqs %0d expected 0 and nonzero", halted, reqs);
    end
`endif
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    exec_instr(16'h0032, 0, 16'h0);
    #1;
    bus.imem_data  = 16'hE7C8;
    bus.imem_valid = 1'b1;
    @(posedge clk); #1;
    bus.imem_valid = 1'b0;           // DECODE
    @(posedge clk); #1;              // EXEC
    @(posedge clk); #1;              // MEM_WR
    checks++;
    if (bus.dmem_wr !== 1'b1 || bus.dmem_addr !== 15'd50) begin
      errors++; $display("FAIL midrst_setup: wr %b addr %h expected 1 0032", bus.dmem_wr, bus.dmem_addr);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.dmem_wr !== 1'b0 || retire !== 1'b0) begin
      errors++; $display("FAIL midrst_drop: wr %b retire %b expected 0 0", bus.dmem_wr, retire);
    end
    checks++;
    if (pc !== 15'd0 || dut.d_reg !== 16'd0) begin
      errors++; $display("FAIL midrst_state: pc %h D %h expected 0000 0000", pc, dut.d_reg);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_a_instr();
    test_c_dmove();
    test_mem_write();
    test_mem_rmw();
    test_jump();
    test_halt();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
